// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone B3 classic master: one bus cycle per command, with a per-cycle watchdog.
// Optional: define WB_INITIATOR_ERR_EN to add wbm_err_i (err > ack > timeout).
module wb_initiator #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_ni,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic                 cmd_we_i,
   input  logic [31:0]          cmd_adr_i,
   input  logic [31:0]          cmd_dat_i,
   input  logic [3:0]           cmd_sel_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [31:0]          rsp_dat_o,
   output logic [1:0]           rsp_status_o,
   output logic [CNT_WIDTH-1:0] txn_count_o,
   output logic                 wbm_cyc_o,
   output logic                 wbm_stb_o,
   output logic                 wbm_we_o,
   output logic [3:0]           wbm_sel_o,
   output logic [31:0]          wbm_adr_o,
   output logic [31:0]          wbm_dat_o,
`ifdef WB_INITIATOR_ERR_EN
   input  logic                 wbm_err_i,
`endif
   input  logic                 wbm_ack_i,
   input  logic [31:0]          wbm_dat_i
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   localparam logic [1:0] ST_ACK = 2'b00;
   localparam logic [1:0] ST_TMO = 2'b01;
   localparam logic [1:0] ST_ERR = 2'b10;
   localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t               state;
   logic [CNT_WIDTH-1:0] tmo_cnt;
   logic                 bus_err;

`ifdef WB_INITIATOR_ERR_EN
   assign bus_err = wbm_err_i;
`else
   assign bus_err = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state        <= IDLE;
         cmd_ready_o  <= 1'b1;
         rsp_valid_o  <= 1'b0;
         rsp_dat_o    <= '0;
         rsp_status_o <= ST_ACK;
         txn_count_o  <= '0;
         tmo_cnt      <= '0;
         wbm_cyc_o    <= 1'b0;
         wbm_stb_o    <= 1'b0;
         wbm_we_o     <= 1'b0;
         wbm_sel_o    <= '0;
         wbm_adr_o    <= '0;
         wbm_dat_o    <= '0;
      end else begin
         case (state)
            IDLE: if (cmd_valid_i) begin
               wbm_we_o    <= cmd_we_i;
               wbm_adr_o   <= cmd_adr_i;
               wbm_dat_o   <= cmd_dat_i;
               wbm_sel_o   <= cmd_sel_i;
               wbm_cyc_o   <= 1'b1;
               wbm_stb_o   <= 1'b1;
               tmo_cnt     <= '0;
               cmd_ready_o <= 1'b0;
               state       <= BUS;
            end
            BUS: begin
               // Any termination drops cyc/stb on the sampling edge and presents the response.
               if (bus_err || wbm_ack_i || tmo_cnt == TMO_LAST) begin
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
                  if (bus_err) begin
                     rsp_dat_o    <= '0;
                     rsp_status_o <= ST_ERR;
                  end else if (wbm_ack_i) begin
                     rsp_dat_o    <= wbm_we_o ? 32'h0 : wbm_dat_i;
                     rsp_status_o <= ST_ACK;
                  end else begin
                     rsp_dat_o    <= '0;
                     rsp_status_o <= ST_TMO;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);
               end
            end
            RESP: if (rsp_ready_i) begin
               rsp_valid_o <= 1'b0;
               txn_count_o <= txn_count_o + CNT_WIDTH'(1);
               cmd_ready_o <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
